time_setter: RTL

Automatic time-setting initiator that drives the user-interface button inputs of time_keeper, the other end of its set-time interface. It accepts a target day/hour/minute, holds set-time active, and emits single-increment button presses. It watches time_keeper's time outputs until each field matches. The block sits beside time_keeper in the thermostat core, so a host or remote-sync controller can set the clock without manual button presses.

---
 rtl/time_setter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/time_setter.sv
// Automatic time-setting initiator: presses time_keeper's incr buttons until day/hour/minute match a target.
// Optional end-of-run re-check of all three fields is built when TIME_SETTER_VERIFY_EN is defined.
module time_setter #(
   parameter int g_press_cycles   = 400,
   parameter int g_release_cycles = 400,
   parameter int g_max_steps      = 64,
   parameter int g_max_passes     = 2
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_start,
   input  logic       i_abort,
   input  logic [6:0] i_tgt_day,
   input  logic [4:0] i_tgt_hour,
   input  logic [5:0] i_tgt_minute,
   input  logic [6:0] i_cur_day,
   input  logic [4:0] i_cur_hour,
   input  logic [5:0] i_cur_minute,
   output logic       o_set_time_n,
   output logic       o_incr_day_n,
   output logic       o_incr_hr_n,
   output logic       o_incr_min_n,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_error
);
   localparam int TMR_MAX = (g_press_cycles > g_release_cycles) ? g_press_cycles : g_release_cycles;
   localparam int TW = $clog2(TMR_MAX + 1);
   localparam int SW = $clog2(g_max_steps + 1);
   localparam logic [TW-1:0] PRESS_LAST = TW'(g_press_cycles - 1);
   localparam logic [TW-1:0] REL_LAST   = TW'(g_release_cycles - 1);
   localparam logic [SW-1:0] STEP_MAX   = SW'(g_max_steps);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CHECK   = 3'd1;
   localparam logic [2:0] S_SEL     = 3'd2;
   localparam logic [2:0] S_PRESS   = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;
   localparam logic [2:0] S_VERIFY  = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;
   localparam logic [2:0] S_ERR     = 3'd7;

   localparam logic [1:0] F_DAY  = 2'd0;
   localparam logic [1:0] F_HOUR = 2'd1;
   localparam logic [1:0] F_MIN  = 2'd2;

   if (g_press_cycles < 1 || g_release_cycles < 1 || g_max_steps < 1 || g_max_passes < 1) begin : g_param_chk
      $error("time_setter: all parameters must be >= 1");
   end

   logic [2:0]    state_q;
   logic [1:0]    fld_q;
   logic [TW-1:0] tmr_q;
   logic [SW-1:0] steps_q;
   logic          err_q;
   logic [6:0]    tgt_day_q;
   logic [4:0]    tgt_hour_q;
   logic [5:0]    tgt_min_q;
   logic          day_match, hour_match, min_match, fld_match, tgt_valid, busy;

`ifdef TIME_SETTER_VERIFY_EN
   localparam int PW = $clog2(g_max_passes + 1);
   localparam logic [PW-1:0] PASS_LAST = PW'(g_max_passes - 1);
   logic [PW-1:0] pass_q;
`endif

   assign day_match  = (i_cur_day == tgt_day_q);
   assign hour_match = (i_cur_hour == tgt_hour_q);
   assign min_match  = (i_cur_minute == tgt_min_q);
   assign tgt_valid  = $onehot(tgt_day_q) && (tgt_hour_q <= 5'd23) && (tgt_min_q <= 6'd59);

   always_comb begin
      fld_match = min_match;
      case (fld_q)
         F_DAY:   fld_match = day_match;
         F_HOUR:  fld_match = hour_match;
         default: fld_match = min_match;
      endcase
   end

   assign busy = (state_q inside {S_CHECK, S_SEL, S_PRESS, S_RELEASE, S_VERIFY});

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= S_IDLE;
         fld_q      <= F_DAY;
         tmr_q      <= '0;
         steps_q    <= '0;
         err_q      <= 1'b0;
         tgt_day_q  <= '0;
         tgt_hour_q <= '0;
         tgt_min_q  <= '0;
`ifdef TIME_SETTER_VERIFY_EN
         pass_q     <= '0;
`endif
      end else if (i_abort && busy) begin
         // abort wins over every busy-state transition; error flag untouched
         state_q <= S_IDLE;
         tmr_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (i_start) begin
               tgt_day_q  <= i_tgt_day;
               tgt_hour_q <= i_tgt_hour;
               tgt_min_q  <= i_tgt_minute;
               err_q      <= 1'b0;
               state_q    <= S_CHECK;
            end
            S_CHECK: begin
               fld_q   <= F_DAY;
               steps_q <= '0;
               tmr_q   <= '0;
`ifdef TIME_SETTER_VERIFY_EN
               pass_q  <= '0;
`endif
               state_q <= tgt_valid ? S_SEL : S_ERR;
            end
            S_SEL: begin
               if (fld_match) begin
                  steps_q <= '0;
                  if (fld_q == F_MIN) begin
`ifdef TIME_SETTER_VERIFY_EN
                     state_q <= S_VERIFY;
`else
                     state_q <= S_DONE;
`endif
                  end else begin
                     fld_q <= fld_q + 2'd1;
                  end
               end else if (steps_q == STEP_MAX) begin
                  state_q <= S_ERR;
               end else begin
                  tmr_q   <= '0;
                  state_q <= S_PRESS;
               end
            end
            S_PRESS: begin
               if (tmr_q == PRESS_LAST) begin
                  tmr_q   <= '0;
                  steps_q <= steps_q + 1'b1;
                  state_q <= S_RELEASE;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            S_RELEASE: begin
               if (tmr_q == REL_LAST) begin
                  tmr_q   <= '0;
                  state_q <= S_SEL;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
`ifdef TIME_SETTER_VERIFY_EN
            S_VERIFY: begin
               // a carry or rollover during setting can disturb an earlier field
               if (day_match && hour_match && min_match) begin
                  state_q <= S_DONE;
               end else if (pass_q == PASS_LAST) begin
                  state_q <= S_ERR;
               end else begin
                  pass_q  <= pass_q + 1'b1;
                  fld_q   <= F_DAY;
                  steps_q <= '0;
                  state_q <= S_SEL;
               end
            end
`endif
            S_ERR: begin
               err_q   <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_busy       = busy;
   assign o_done       = (state_q == S_DONE);
   assign o_error      = err_q | (state_q == S_ERR);
   assign o_set_time_n = !(state_q inside {S_SEL, S_PRESS, S_RELEASE, S_VERIFY});
   assign o_incr_day_n = !((state_q == S_PRESS) && (fld_q == F_DAY));
   assign o_incr_hr_n  = !((state_q == S_PRESS) && (fld_q == F_HOUR));
   assign o_incr_min_n = !((state_q == S_PRESS) && (fld_q == F_MIN));

endmodule
